// File: rtl/fb_inst_enc_pkg.sv
// Types and helpers shared by the instruction encoder and its packing stage.
`include "fb_defines.v"

package fb_inst_enc_pkg;

   // Instruction format chosen from opcode[6:2]
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_J = 3'd4
   } fmt_t;

   // One encoded result: the word plus its range-error flag
   typedef struct packed {
      logic        err;
      logic [31:0] inst;
   } enc_t;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   // Map opcode[6:2] to a format; anything unlisted is treated as R
   function automatic fmt_t fmt_decode(input logic [4:0] op5);
      fmt_t f;
      case (op5)
         `FB_OPC_LOAD,
         `FB_OPC_OPIMM,
         `FB_OPC_JALR:   f = FMT_I;
         `FB_OPC_STORE:  f = FMT_S;
         `FB_OPC_BRANCH: f = FMT_B;
         `FB_OPC_JAL:    f = FMT_J;
         default:        f = FMT_R;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/fb_defines.v
// Shared instruction-format definitions used across the fetch/decode blocks.
`ifndef FB_DEFINES_V
`define FB_DEFINES_V

`define FB_32BITS     31:0

// opcode[6:2] values that select a non-R immediate format
`define FB_OPC_LOAD   5'b00000
`define FB_OPC_OPIMM  5'b00100
`define FB_OPC_JALR   5'b11001
`define FB_OPC_STORE  5'b01000
`define FB_OPC_BRANCH 5'b11000
`define FB_OPC_JAL    5'b11011

`endif

// File: rtl/fb_imm_pack.sv
// Combinational packing stage: picks the format, scatters the fields and
// immediate into the instruction word, and flags immediates that do not fit.
`include "fb_defines.v"

module fb_imm_pack
   import fb_inst_enc_pkg::*;
(
   input  logic [6:0]          i_opcode,
   input  logic [4:0]          i_rd,
   input  logic [4:0]          i_rs1,
   input  logic [4:0]          i_rs2,
   input  logic [2:0]          i_funct3,
   input  logic [6:0]          i_funct7,
   input  logic [`FB_32BITS]   i_imm,
   output enc_t                o_enc
);

   fmt_t        w_fmt;
   logic        w_fit12;
   logic        w_fit20;
   logic [31:0] w_inst;
   logic        w_err;

   assign w_fmt   = fmt_decode(i_opcode[6:2]);
   // An immediate fits when every bit above the field's sign bit matches it
   assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
   assign w_fit20 = (&i_imm[31:19]) | ~(|i_imm[31:19]);

   // Field placement per format; out-of-range immediates are still truncated in
   always_comb begin
      w_inst      = '0;
      w_err       = 1'b0;
      w_inst[6:0] = i_opcode;
      case (w_fmt)
         FMT_I: begin
            w_inst[11:7]  = i_rd;
            w_inst[14:12] = i_funct3;
            w_inst[19:15] = i_rs1;
            w_inst[31:20] = i_imm[11:0];
            w_err         = ~w_fit12;
         end
         FMT_S: begin
            w_inst[11:7]  = i_imm[4:0];
            w_inst[14:12] = i_funct3;
            w_inst[19:15] = i_rs1;
            w_inst[24:20] = i_rs2;
            w_inst[31:25] = i_imm[11:5];
            w_err         = ~w_fit12;
         end
         FMT_B: begin
            // Unshifted branch layout: imm[0] is a real offset bit here
            w_inst[7]     = i_imm[10];
            w_inst[11:8]  = i_imm[3:0];
            w_inst[14:12] = i_funct3;
            w_inst[19:15] = i_rs1;
            w_inst[24:20] = i_rs2;
            w_inst[30:25] = i_imm[9:4];
            w_inst[31]    = i_imm[11];
            w_err         = ~w_fit12;
         end
         FMT_J: begin
            w_inst[11:7]  = i_rd;
            w_inst[19:12] = i_imm[18:11];
            w_inst[20]    = i_imm[10];
            w_inst[30:21] = i_imm[9:0];
            w_inst[31]    = i_imm[19];
            w_err         = ~w_fit20;
         end
         default: begin
            w_inst[11:7]  = i_rd;
            w_inst[14:12] = i_funct3;
            w_inst[19:15] = i_rs1;
            w_inst[24:20] = i_rs2;
            w_inst[31:25] = i_funct7;
         end
      endcase
   end

   assign o_enc.inst = w_inst;
   assign o_enc.err  = w_err;

endmodule

// File: rtl/fb_inst_enc.sv
// Instruction encoder with a 2-entry skid buffer on the output.
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side; in_ready is a register equal to "skid empty", so it never depends
// combinationally on out_ready, and words leave in strict acceptance order.
`include "fb_defines.v"

module fb_inst_enc
   import fb_inst_enc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [6:0]          in_opcode,
   input  logic [4:0]          in_rd,
   input  logic [4:0]          in_rs1,
   input  logic [4:0]          in_rs2,
   input  logic [2:0]          in_funct3,
   input  logic [6:0]          in_funct7,
   input  logic [`FB_32BITS]   in_imm,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [`FB_32BITS]   out_inst,
   output logic                out_err,
   output logic [15:0]         enc_cnt,
   output logic [7:0]          err_cnt
);

   enc_t        w_enc;
   logic        w_in_xfer;
   logic        w_out_load;
   logic        w_skid_nxt;

   enc_t        r_out;
   logic        r_out_valid;
   enc_t        r_skid;
   logic        r_skid_valid;
   logic        r_in_ready;
   logic [15:0] r_enc_cnt;
   logic [7:0]  r_err_cnt;

   fb_imm_pack u_pack (
      .i_opcode (in_opcode),
      .i_rd     (in_rd),
      .i_rs1    (in_rs1),
      .i_rs2    (in_rs2),
      .i_funct3 (in_funct3),
      .i_funct7 (in_funct7),
      .i_imm    (in_imm),
      .o_enc    (w_enc)
   );

   assign w_in_xfer  = in_valid & r_in_ready;
   // Output register can take a new word when empty or being drained
   assign w_out_load = ~r_out_valid | out_ready;

   // Next skid occupancy: it empties into the output register on a load,
   // otherwise it captures the incoming word while the output is stalled
   always_comb begin
      w_skid_nxt = r_skid_valid;
      if (w_out_load) begin
         w_skid_nxt = r_skid_valid & w_in_xfer;
      end else if (w_in_xfer) begin
         w_skid_nxt = 1'b1;
      end
   end

   // Output and skid registers, plus the registered in_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         if (w_out_load) begin
            if (r_skid_valid) begin
               r_out       <= r_skid;
               r_out_valid <= 1'b1;
               if (w_in_xfer) begin
                  r_skid <= w_enc;
               end
            end else begin
               r_out_valid <= w_in_xfer;
               if (w_in_xfer) begin
                  r_out <= w_enc;
               end
            end
         end else if (w_in_xfer) begin
            r_skid <= w_enc;
         end
         r_skid_valid <= w_skid_nxt;
         r_in_ready   <= ~w_skid_nxt;
      end
   end

   // Accepted-request counter (wraps) and range-error counter (saturates)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enc_cnt <= '0;
         r_err_cnt <= '0;
      end else if (w_in_xfer) begin
         r_enc_cnt <= r_enc_cnt + 16'd1;
         if (w_enc.err && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_inst  = r_out.inst;
   assign out_err   = r_out.err;
   assign enc_cnt   = r_enc_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_fb_inst_enc.sv
// Directed and random checks of fb_inst_enc with an expected-word queue.
module tb_fb_inst_enc;

   localparam int W = 65; // {err, inst[31:0], imm[31:0]}

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [15:0] enc_cnt;
   logic [7:0]  err_cnt;

   fb_inst_enc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .enc_cnt   (enc_cnt),
      .err_cnt   (err_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   logic [15:0]  exp_enc = '0;
   logic [7:0]   exp_errc = '0;
   logic         rnd_bp = 1'b0;

   // 0=R 1=I 2=S 3=B 4=J
   function automatic int fmt_of(input logic [4:0] op5);
      case (op5)
         5'b00000, 5'b00100, 5'b11001: return 1;
         5'b01000: return 2;
         5'b11000: return 3;
         5'b11011: return 4;
         default:  return 0;
      endcase
   endfunction

   // Reference encoder: builds the word by concatenation, range by arithmetic
   function automatic logic [W-1:0] model(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
      logic [31:0] ins;
      logic        err;
      int signed   s;
      s = $signed(imm);
      err = 1'b0;
      case (fmt_of(op[6:2]))
         1: begin ins = {imm[11:0], rs1, f3, rd, op}; err = (s < -2048) || (s > 2047); end
         2: begin ins = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; err = (s < -2048) || (s > 2047); end
         3: begin ins = {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], op};
                  err = (s < -2048) || (s > 2047); end
         4: begin ins = {imm[19], imm[9:0], imm[10], imm[18:11], rd, op};
                  err = (s < -524288) || (s > 524287); end
         default: ins = {f7, rs2, rs1, f3, rd, op};
      endcase
      return {err, ins, imm};
   endfunction

   // Pipeline-side immediate decoder used for the round trip
   function automatic logic [31:0] dec(input logic [31:0] ins);
      logic [31:0] r;
      case (fmt_of(ins[6:2]))
         1: r = {{20{ins[31]}}, ins[31:20]};
         2: r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         3: r = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
         4: r = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Sample outputs/acceptance for this cycle, then advance to the next negedge
   task automatic clk_step();
      logic [W-1:0] e;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", {31'b0, out_valid}, 32'd0);
         end else begin
            e = exp_q[0];
            chk("out_inst", out_inst, e[63:32]);
            chk("out_err", {31'b0, out_err}, {31'b0, e[64]});
            if (out_ready) begin
               void'(exp_q.pop_front());
               if (!e[64] && fmt_of(e[38:34]) != 0)
                  chk("round_trip", dec(out_inst), e[31:0]);
            end
         end
      end
      if (in_valid && in_ready) begin
         e = model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
         exp_q.push_back(e);
         exp_enc++;
         if (e[64] && exp_errc != 8'd255) exp_errc++;
      end
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
      logic acc;
      int   n;
      drive(op, rd, rs1, rs2, f3, f7, imm);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 64) begin
         if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
         acc = in_ready;
         clk_step();
         n++;
      end
      if (!acc) chk("accept_timeout", {31'b0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         clk_step();
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [15:0] base;
      logic [31:0] r;
      logic [4:0]  op5;
      logic [31:0] imm;
      logic [4:0]  op_tab [8];
      op_tab = '{5'b00000, 5'b00100, 5'b11001, 5'b01000,
                 5'b11000, 5'b11011, 5'b01100, 5'b00101};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_err", {31'b0, out_err}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
      chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // I with all-ones immediate, one-cycle latency
      send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
      chk("i_latency", {31'b0, out_valid}, 32'd1);
      chk("i_word", out_inst, 32'hFFF1_0093);
      drain();

      send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
      chk("s_word", out_inst, 32'h0051_2423);
      drain();
      send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4);
      chk("b_word", out_inst, 32'h0020_8463);
      drain();
      send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h10);
      chk("j_word", out_inst, 32'h0200_00EF);
      drain();
      send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h800);
      chk("i_range_err", {31'b0, out_err}, 32'd1);
      drain();
      chk("err_cnt_one", {24'b0, err_cnt}, 32'd1);
      // R never flags, whatever the immediate
      send(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd7, 7'b0100000, 32'hDEAD_BEEF);
      drain();
      chk("enc_cnt_dir", {16'b0, enc_cnt}, {16'b0, exp_enc});

      // Back-pressure: third request must wait for the skid to empty
      out_ready = 1'b0;
      base = exp_enc;
      drive(7'b0010011, 5'd10, 5'd11, 5'd0, 3'd1, 7'd0, 32'h7FF);
      clk_step();
      drive(7'b0100011, 5'd0, 5'd12, 5'd13, 3'd2, 7'd0, 32'hFFFF_F800);
      clk_step();
      drive(7'b1101111, 5'd14, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF8_0000);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_accepted", {16'b0, enc_cnt}, {16'b0, base + 16'd2});
      clk_step();
      chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      send(7'b1101111, 5'd14, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF8_0000);
      drain();
      chk("bp_all_three", {16'b0, enc_cnt}, {16'b0, base + 16'd3});

      // Reset with both entries occupied
      out_ready = 1'b0;
      send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
      send(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2);
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("mid_rst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
      chk("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
      exp_q.delete();
      exp_enc = '0;
      exp_errc = '0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) clk_step();
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

      // Range errors across formats, then saturate the error counter
      send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h800);
      send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8_0000);
      send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_F7FF);
      for (int i = 0; i < 260; i++)
         send(7'b0000011, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'h1000);
      drain();
      chk("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
      chk("enc_cnt_sat", {16'b0, enc_cnt}, {16'b0, exp_enc});

      // Random in-range round trip with random back-pressure and gaps
      rnd_bp = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         r = $urandom();
         op5 = op_tab[$urandom_range(0, 7)];
         case (fmt_of(op5))
            1, 2, 3: imm = {{20{r[11]}}, r[11:0]};
            4:       imm = {{12{r[19]}}, r[19:0]};
            default: imm = $urandom();
         endcase
         r = $urandom();
         send({op5, 2'b11}, r[4:0], r[9:5], r[14:10], r[17:15], r[24:18], imm);
         if ($urandom_range(0, 7) == 0) begin
            out_ready = ($urandom_range(0, 1) != 0);
            clk_step();
         end
      end
      rnd_bp = 1'b0;
      drain();
      chk("enc_cnt_final", {16'b0, enc_cnt}, {16'b0, exp_enc});
      chk("err_cnt_final", {24'b0, err_cnt}, {24'b0, exp_errc});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fb_inst_enc.md
FB_INST_ENC -- requirements
Module: fb_inst_enc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder can accept a request.
REQ-005 SHALL have ports in_opcode[6:0], in_rd[4:0], in_rs1[4:0], in_rs2[4:0], in_funct3[2:0], in_funct7[6:0], all inputs: instruction fields.
REQ-006 SHALL have port in_imm, input, `FB_32BITS: immediate, in the same bit convention the pipeline immediate decoder produces.
REQ-007 SHALL have port out_valid, output, 1 bit: encoded word valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-009 SHALL have port out_inst, output, `FB_32BITS: encoded instruction.
REQ-010 SHALL have port out_err, output, 1 bit: immediate out of range, qualified by out_valid.
REQ-011 SHALL have port enc_cnt, output, 16 bits: accepted-request count, wrapping.
REQ-012 SHALL have port err_cnt, output, 8 bits: range-error count, saturating at 255.

Function
REQ-013 SHALL select the format from in_opcode[6:2]: 00000, 00100 or 11001 is I; 01000 is S; 11000 is B; 11011 is J; any other value is R.
REQ-014 SHALL place opcode at [6:0], rd at [11:7] (I, J, R), funct3 at [14:12] (I, S, B, R), rs1 at [19:15] (I, S, B, R), rs2 at [24:20] (S, B, R), and funct7 at [31:25] (R only).
REQ-015 SHALL encode I as inst[31:20]=imm[11:0].
REQ-016 SHALL encode S as inst[31:25]=imm[11:5] and inst[11:7]=imm[4:0].
REQ-017 SHALL encode B unshifted as inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0].
REQ-018 SHALL encode J as inst[31]=imm[19], inst[19:12]=imm[18:11], inst[20]=imm[10], inst[30:21]=imm[9:0].
REQ-019 SHALL guarantee that decoding out_inst with the pipeline decoder returns in_imm whenever out_err=0.
REQ-020 SHALL set out_err=1 when imm[31:11] are not all equal (I, S, B) or imm[31:19] are not all equal (J), still emit the truncated encoding, and never set out_err for R.
REQ-021 SHALL define a transfer as valid&&ready on each side and preserve strict FIFO order.
REQ-022 SHALL buffer results in a 2-entry skid: an output register plus one skid register.
REQ-023 SHALL present a request accepted in cycle N at the output in cycle N+1 when the output register is empty, or when it is draining in cycle N.
REQ-024 SHALL drive in_ready = !skid_valid as a registered signal with no combinational path from out_ready.
REQ-025 SHALL, when out_ready=0 with the output register full, move the next accepted request into the skid register, dropping in_ready in the following cycle.
REQ-026 SHALL, on output drain, move the skid entry into the output register in the same edge, and a request accepted in that same cycle goes to the skid register.
REQ-027 SHALL increment enc_cnt on each input transfer, wrapping from 0xFFFF to 0.
REQ-028 SHALL increment err_cnt on each input transfer with a range error, holding at 255.
REQ-029 SHALL hold out_inst and out_err stable while out_valid=1 and out_ready=0.

Reset
REQ-030 SHALL on rst drive out_valid=0, out_inst=0, out_err=0, skid empty, in_ready=1 (registered), enc_cnt=0, err_cnt=0.
REQ-031 SHALL discard in-flight entries on rst asserted mid-transfer, with no output produced for them after release.

Structure
REQ-032 SHALL take `FB_32BITS and the format opcode constants (00000, 00100, 11001, 01000, 11000, 11011) from the shared fb_defines.v.
REQ-033 SHALL place format select, field packing and range check in one combinational sub-module, fb_imm_pack, instantiated once at the input; all registers stay in fb_inst_enc.

Verification
REQ-034 SHALL check: I opcode=0010011, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF -> out_inst=0xFFF10093, out_err=0, one cycle later.
REQ-035 SHALL check: S opcode=0100011, f3=2, rs1=2, rs2=5, imm=8 -> 0x00512423; and B opcode=1100011, rs1=1, rs2=2, imm=4 -> 0x00208463.
REQ-036 SHALL check: J opcode=1101111, rd=1, imm=0x10 -> 0x020000EF; and I with imm=0x800 -> out_err=1, err_cnt=1.
REQ-037 SHALL check: out_ready=0, three back-to-back requests -> two accepted, in_ready=0; then out_ready=1 -> all three words out in order, none lost or duplicated.
REQ-038 SHALL check: rst pulsed with both entries full -> out_valid=0, in_ready=1, counters 0; random round-trip through the decoder matches in_imm for 10k in-range requests.
